// File: rtl/mac_accumulator_if.sv
// Handshake bundle between the product source, the MAC accumulator and the result consumer.
interface mac_accumulator_if #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned LEN_W = 4
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [7:0]       prod;
  logic             prod_valid;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic             res_valid;
  logic             res_ready;
  logic             ovf;
  logic             busy;

  modport master (
    output start, len, prod, prod_valid, res_ready,
    input  prod_ready, acc_out, res_valid, ovf, busy
  );

  modport slave (
    input  start, len, prod, prod_valid, res_ready,
    output prod_ready, acc_out, res_valid, ovf, busy
  );
endinterface

// File: rtl/mac_accumulator.sv
// Sequential MAC back end: sums a burst of 8-bit products into an ACC_W-bit
// accumulator and hands the dot-product result out over a valid/ready handshake.
module mac_accumulator #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned LEN_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  mac_accumulator_if.slave bus
);
  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic             ovf;
  logic             ovf_nxt;
  logic             prod_ready;
  logic             res_valid;
  logic             busy;
  logic [SUM_W-1:0] sum;

  // One extra bit captures the carry out of the accumulator MSB.
  assign sum = SUM_W'(acc) + SUM_W'(bus.prod);

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          acc_nxt = '0;
          ovf_nxt = 1'b0;
          if (bus.len != '0) begin
            cnt_nxt   = bus.len;
            state_nxt = S_ACCUM;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_ACCUM: begin
        if (bus.prod_valid) begin
          acc_nxt = sum[ACC_W-1:0];
          ovf_nxt = ovf | sum[ACC_W];
          cnt_nxt = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they are flops, not gates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      prod_ready <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      ovf        <= ovf_nxt;
      prod_ready <= (state_nxt == S_ACCUM);
      res_valid  <= (state_nxt == S_DONE);
      busy       <= (state_nxt != S_IDLE);
    end
  end

  assign bus.prod_ready = prod_ready;
  assign bus.res_valid  = res_valid;
  assign bus.busy       = busy;
  assign bus.acc_out    = acc;
  assign bus.ovf        = ovf;
endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed scenarios plus random bursts on a 16-bit
// and an 8-bit accumulator, checked against an arithmetic sum model.
module tb_mac_accumulator;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mac_accumulator_if #(.ACC_W(16), .LEN_W(4)) b16 ();
  mac_accumulator_if #(.ACC_W(8),  .LEN_W(4)) b8 ();

  mac_accumulator #(.ACC_W(16), .LEN_W(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
  mac_accumulator #(.ACC_W(8),  .LEN_W(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  logic [7:0] pq[$];
  bit         vq[$];
  int         exp_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int w, input logic st, input logic [3:0] ln, input logic pv,
                     input logic [7:0] p, input logic rr);
    if (w == 8) begin
      b8.start = st; b8.len = ln; b8.prod_valid = pv; b8.prod = p; b8.res_ready = rr;
    end else begin
      b16.start = st; b16.len = ln; b16.prod_valid = pv; b16.prod = p; b16.res_ready = rr;
    end
  endtask

  function automatic logic [31:0] g_acc(input int w);
    return (w == 8) ? 32'(b8.acc_out) : 32'(b16.acc_out);
  endfunction
  function automatic logic [31:0] g_rv(input int w);
    return (w == 8) ? 32'(b8.res_valid) : 32'(b16.res_valid);
  endfunction
  function automatic logic [31:0] g_pr(input int w);
    return (w == 8) ? 32'(b8.prod_ready) : 32'(b16.prod_ready);
  endfunction
  function automatic logic [31:0] g_busy(input int w);
    return (w == 8) ? 32'(b8.busy) : 32'(b16.busy);
  endfunction
  function automatic logic [31:0] g_ovf(input int w);
    return (w == 8) ? 32'(b8.ovf) : 32'(b16.ovf);
  endfunction

  // Start a burst of n products and feed pq/vq; the expected result is the plain
  // sum reduced modulo 2**w, and overflow is whether the true sum reached 2**w.
  task automatic run_burst(input int w, input int n, input string tag);
    int total = 0;
    drv(w, 1'b1, 4'(n), 1'b0, 8'd0, 1'b0);
    cyc();
    drv(w, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    if (n != 0) check({tag, ".prod_ready"}, g_pr(w), 32'd1);
    foreach (vq[i]) begin
      if (i == vq.size() - 1) check({tag, ".res_valid_early"}, g_rv(w), 32'd0);
      drv(w, 1'b0, 4'd0, vq[i], vq[i] ? pq[i] : 8'($urandom), 1'b0);
      if (vq[i]) total += int'(pq[i]);
      cyc();
    end
    drv(w, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    exp_acc = total % (1 << w);
    check({tag, ".res_valid"}, g_rv(w), 32'd1);
    check({tag, ".acc"}, g_acc(w), 32'(exp_acc));
    check({tag, ".ovf"}, g_ovf(w), (total >= (1 << w)) ? 32'd1 : 32'd0);
    check({tag, ".prod_ready_done"}, g_pr(w), 32'd0);
  endtask

  task automatic finish_burst(input int w, input string tag);
    drv(w, 1'b0, 4'd0, 1'b0, 8'd0, 1'b1);
    cyc();
    drv(w, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    check({tag, ".idle_busy"}, g_busy(w), 32'd0);
    check({tag, ".idle_rv"}, g_rv(w), 32'd0);
    check({tag, ".idle_acc_hold"}, g_acc(w), 32'(exp_acc));
  endtask

  task automatic load(input logic [7:0] p[], input bit v[]);
    pq.delete(); vq.delete();
    foreach (v[i]) begin
      pq.push_back(p[i]);
      vq.push_back(v[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drv(16, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    drv(8,  1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    #1;
    check("rst.acc",  g_acc(16),  32'd0);
    check("rst.rv",   g_rv(16),   32'd0);
    check("rst.pr",   g_pr(16),   32'd0);
    check("rst.busy", g_busy(16), 32'd0);
    check("rst.ovf",  g_ovf(16),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Back-to-back burst.
    load('{8'd6, 8'd225, 8'd0}, '{1'b1, 1'b1, 1'b1});
    run_burst(16, 3, "t1");
    check("t1.acc_231", g_acc(16), 32'd231);
    finish_burst(16, "t1");

    // Bubbles between valid products.
    load('{8'd15, 8'd0, 8'd0, 8'd30, 8'd45, 8'd0, 8'd60},
         '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
    run_burst(16, 4, "t2");
    check("t2.acc_150", g_acc(16), 32'd150);
    finish_burst(16, "t2");

    // Empty burst goes straight to DONE.
    pq.delete(); vq.delete();
    run_burst(16, 0, "t3");
    check("t3.busy", g_busy(16), 32'd1);
    finish_burst(16, "t3");

    // Wrap on the 8-bit accumulator, then a fresh burst clears ovf.
    load('{8'd200, 8'd100}, '{1'b1, 1'b1});
    run_burst(8, 2, "t4a");
    check("t4a.acc_44", g_acc(8), 32'd44);
    finish_burst(8, "t4a");
    load('{8'd5}, '{1'b1});
    run_burst(8, 1, "t4b");
    check("t4b.ovf_clear", g_ovf(8), 32'd0);
    finish_burst(8, "t4b");

    // Back-pressure in DONE with start pulses that must be ignored.
    load('{8'd17, 8'd3}, '{1'b1, 1'b1});
    run_burst(16, 2, "t5");
    for (int i = 0; i < 5; i++) begin
      drv(16, (i == 2), 4'd3, 1'b1, 8'd99, 1'b0);
      cyc();
      check("t5.hold_rv",  g_rv(16),  32'd1);
      check("t5.hold_acc", g_acc(16), 32'd20);
    end
    drv(16, 1'b1, 4'd3, 1'b0, 8'd0, 1'b1);
    cyc();
    drv(16, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    check("t5.idle_busy", g_busy(16), 32'd0);
    cyc();
    check("t5.stay_idle", g_busy(16), 32'd0);
    check("t5.acc_kept",  g_acc(16),  32'd20);

    // Asynchronous reset in the middle of a burst.
    drv(16, 1'b1, 4'd4, 1'b0, 8'd0, 1'b0);
    cyc();
    drv(16, 1'b0, 4'd0, 1'b1, 8'd50, 1'b0);
    cyc();
    cyc();
    drv(16, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6.acc",  g_acc(16),  32'd0);
    check("t6.pr",   g_pr(16),   32'd0);
    check("t6.busy", g_busy(16), 32'd0);
    check("t6.rv",   g_rv(16),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    load('{8'd9}, '{1'b1});
    run_burst(16, 1, "t6b");
    check("t6b.acc_9", g_acc(16), 32'd9);
    finish_burst(16, "t6b");

    // Random bursts with random gaps on both widths.
    for (int b = 0; b < 24; b++) begin
      int w = (b % 2 == 0) ? 16 : 8;
      int n = int'($urandom_range(0, 15));
      pq.delete(); vq.delete();
      for (int k = 0; k < n; k++) begin
        int gaps = int'($urandom_range(0, 2));
        for (int g = 0; g < gaps; g++) begin
          pq.push_back(8'd0);
          vq.push_back(1'b0);
        end
        pq.push_back(8'($urandom));
        vq.push_back(1'b1);
      end
      run_burst(w, n, $sformatf("rnd%0d", b));
      finish_burst(w, $sformatf("rnd%0d", b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
